// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 shift-add multiplier sequencer.
// State encoding is exposed on the State port for LED debug.
package mult_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: accumulator, multiplicand/multiplier
// shift registers and iteration counter.
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last_iter,
  output logic [2*WIDTH-1:0] sum
);

  localparam int CW = cnt_w(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // sum already includes the current iteration's partial product
  assign sum       = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (init) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Operand-loading and compute controller for the multiplier path:
// Valid-strobed A then B capture, WIDTH-cycle run, held Product.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Valid,
  input  logic [WIDTH-1:0]   Data,
  output logic               Ready,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic [STATE_W-1:0] State
);

  state_t st_q, st_d;

  logic               cap_a;
  logic               cap_b;
  logic               init;
  logic               step;
  logic               last_iter;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod_q;

  mult_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (Clk),
    .rst      (Rst),
    .init     (init),
    .step     (step),
    .a        (a_q),
    .b        (Data),
    .last_iter(last_iter),
    .sum      (sum)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st_q <= ST_LOAD_A;
    end else begin
      st_q <= st_d;
    end
  end

  // Valid is only honoured in Ready states; RUN drops it
  always_comb begin
    st_d  = st_q;
    cap_a = 1'b0;
    cap_b = 1'b0;
    init  = 1'b0;
    step  = 1'b0;
    unique case (st_q)
      ST_LOAD_A: begin
        if (Valid) begin
          cap_a = 1'b1;
          st_d  = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (Valid) begin
          cap_b = 1'b1;
          init  = 1'b1;
          st_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_iter) begin
          st_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Valid) begin
          cap_a = 1'b1;
          st_d  = ST_LOAD_B;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      if (cap_a) begin
        a_q <= Data;
      end
      if (cap_b) begin
        b_q <= Data;
      end
      if (step && last_iter) begin
        prod_q <= sum;
      end
    end
  end

  assign Ready   = (st_q != ST_RUN);
  assign Busy    = (st_q == ST_RUN);
  assign Done    = (st_q == ST_DONE);
  assign A       = a_q;
  assign B       = b_q;
  assign Product = prod_q;
  assign State   = st_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: vector table, directed corner
// sequences and randomized operands against a product model.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  data = '0;
  logic        ready, busy, done;
  logic [7:0]  a, b;
  logic [15:0] product;
  logic [1:0]  state;

  int compared = 0;
  int mismatched = 0;

  mult_sequencer #(.WIDTH(8)) dut (
    .Clk    (clk),
    .Rst    (rst),
    .Valid  (valid),
    .Data   (data),
    .Ready  (ready),
    .Busy   (busy),
    .Done   (done),
    .A      (a),
    .B      (b),
    .Product(product),
    .State  (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Waits for completion after B capture; optional noise strobes
  // on RUN cycles nz1/nz2 which must be ignored.
  task automatic wait_done(input string name, input logic [15:0] exp,
                           input int nz1, input int nz2);
    logic [15:0] prev;
    int lat;
    bit  stable;
    prev   = product;
    lat    = 0;
    stable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      valid = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (product !== prev) stable = 1'b0;
      if (n == nz1 || n == nz2) begin
        check({name, " ready_in_run"}, 32'(ready), 32'd0);
        valid = 1'b1;
        data  = 8'h55;
      end
    end
    valid = 1'b0;
    check({name, " latency"}, lat, 8);
    check({name, " no_partial"}, 32'(stable), 32'd1);
    check({name, " product"}, 32'(product), 32'(exp));
    check({name, " ready"}, 32'(ready), 32'd1);
    check({name, " state"}, 32'(state), 32'd3);
  endtask

  task automatic run_mult(input string name, input logic [7:0] x,
                          input logic [7:0] y, input logic [15:0] exp,
                          input int nz1, input int nz2);
    strobe(x);
    strobe(y);
    check({name, " A"}, 32'(a), 32'(x));
    check({name, " B"}, 32'(b), 32'(y));
    check({name, " busy"}, 32'(busy), 32'd1);
    wait_done(name, exp, nz1, nz2);
    check({name, " A_hold"}, 32'(a), 32'(x));
    check({name, " B_hold"}, 32'(b), 32'(y));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'h0000};
    vecs[3] = '{8'd200, 8'd0,   16'h0000};
    vecs[4] = '{8'd1,   8'd1,   16'h0001};
    vecs[5] = '{8'd128, 8'd2,   16'h0100};
    vecs[6] = '{8'd7,   8'd9,   16'h003F};
    vecs[7] = '{8'd255, 8'd1,   16'h00FF};
    vecs[8] = '{8'd170, 8'd85,  16'h3872};
    vecs[9] = '{8'd16,  8'd16,  16'h0100};

    @(negedge clk);
    check("rst state", 32'(state), 32'd0);
    check("rst ready", 32'(ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst product", 32'(product), 32'd0);
    check("rst A", 32'(a), 32'd0);
    check("rst B", 32'(b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, chained through DONE
    foreach (vecs[i])
      run_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
               vecs[i].p, 0, 0);

    // Ignored strobes on RUN cycles 2 and 5
    run_mult("noise", 8'd13, 8'd11, 16'h008F, 2, 5);

    // Reset mid-RUN aborts, then restart
    strobe(8'd100);
    strobe(8'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort state", 32'(state), 32'd0);
    check("abort product", 32'(product), 32'd0);
    check("abort A", 32'(a), 32'd0);
    check("abort B", 32'(b), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_mult("restart", 8'd7, 8'd9, 16'h003F, 0, 0);

    // New A from DONE keeps old Product until next completion
    run_mult("pre", 8'd13, 8'd11, 16'h008F, 0, 0);
    strobe(8'd2);
    check("redo state", 32'(state), 32'd1);
    check("redo product", 32'(product), 32'h008F);
    check("redo A", 32'(a), 32'd2);
    strobe(8'd128);
    wait_done("redo", 16'h0100, 0, 0);

    // Valid held three cycles from LOAD_A
    do_reset();
    valid = 1'b1;
    data  = 8'd5;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    check("hold A", 32'(a), 32'd5);
    check("hold B", 32'(b), 32'd5);
    check("hold busy", 32'(busy), 32'd1);
    for (int n = 0; n < 20 && !done; n++) @(negedge clk);
    check("hold done", 32'(done), 32'd1);
    check("hold product", 32'(product), 32'h0019);

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_mult($sformatf("rnd%0d", i), ra, rb,
               16'(32'(ra) * 32'(rb)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
